gb_fb_write_ctrl: RTL
=====================

# gb_fb_write_ctrl

Write-port controller for the GameBoy LCD frame buffer (160x144 pixels, 2 bits each, 23040 entries). It sits in the GameBoy clock domain between the PPU pixel stream and the frame buffer RAM write port. It shares that port between three sources: the streaming PPU pixels, a host-triggered clear/fill sequencer, and single-pixel host pokes over Avalon. It also keeps the linear write pointer and its frame synchronisation.

## Interface
- `FB_DEPTH`, 23040: frame buffer entries; write pointer wraps at `FB_DEPTH-1`.
- `ADDR_WIDTH`, 15: frame buffer address width.
- `clk` in 1: GameBoy clock, 2^22 Hz; all logic on rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `px_valid` in 1: PPU pixel strobe, one pixel per cycle when high.
- `px_data` in 2: PPU pixel shade.
- `frame_start` in 1: single-cycle pulse that accompanies the first pixel of a frame.
- `chipselect` in 1: Avalon slave select.
- `write` in 1: Avalon write.
- `address` in 2: register index.
- `writedata` in 8: Avalon write data.
- `waitrequest` out 1: Avalon stall.
- `fb_we` out 1: frame buffer write enable (registered).
- `fb_addr` out `ADDR_WIDTH`: frame buffer write address (registered).
- `fb_data` out 2: frame buffer write data (registered).
- `busy` out 1: high while a clear is running or a poke is pending.
- `frame_done` out 1: one-cycle pulse when the write pointer wraps.

## Operation
- Registers (write-only):
  - 0 CTRL: bit0 writes 1 to start a clear (self-clearing); bit1 `freeze`, which suppresses PPU writes while the pointer keeps advancing; bits3:2 `fill` shade.
  - 1 POKE_LO: poke address [7:0].
  - 2 POKE_HI: poke address [14:8].
  - 3 POKE_DATA: bits1:0 are the shade; the write arms a poke.
- Write pointer `wp`:
  - Each `px_valid` consumes address `wp`, then `wp` becomes `wp+1`, or 0 if `wp==FB_DEPTH-1`.
  - `frame_start` together with `px_valid` consumes address 0 and sets `wp` to 1.
  - `frame_start` without `px_valid` sets `wp` to 0.
  - The pointer advances on every `px_valid`, regardless of freeze, clear or poke.
  - `frame_done` pulses the cycle after the wrap from `FB_DEPTH-1`.
- State machine:
  - States are IDLE, CLEAR and POKE_WAIT.
  - IDLE -> CLEAR on a CTRL write with bit0=1. The clear counter `cc` starts at 0.
  - IDLE -> POKE_WAIT on a POKE_DATA write.
  - CLEAR writes `fill` to `cc` every cycle, ignoring `px_valid`. PPU pixels are dropped while a clear runs.
  - CLEAR -> IDLE after the cycle that writes `FB_DEPTH-1`, so a clear takes exactly `FB_DEPTH` cycles.
  - POKE_WAIT writes the poke on the first cycle where `px_valid==0`, or where `px_valid==1` with freeze set. It then returns to IDLE.
- Port priority: CLEAR, then PPU (unless frozen), then poke.
- Host stalls:
  - `waitrequest` is asserted combinationally for a POKE_DATA write while in POKE_WAIT.
  - `waitrequest` is asserted for any CTRL start-clear write while not in IDLE.
  - All other register writes complete in one cycle, including during CLEAR.
  - Writes to POKE_LO/POKE_HI during POKE_WAIT update the registers but do not change the pending poke's latched address.
- A poke address at or above `FB_DEPTH` is discarded: no write is issued and the block returns to IDLE.

## Timing
- Reset values:
  - `fb_we`, `fb_addr`, `fb_data`, `busy`, `frame_done`, `waitrequest` are all 0.
  - `wp`=0, state IDLE.
  - freeze=0, fill=0, poke registers 0.
- Latency:
  - A PPU pixel accepted in cycle N appears on `fb_*` in cycle N+1.
  - In a CLEAR, the first write appears the cycle after the CTRL write.
  - `busy` rises the cycle after the triggering write and falls the cycle after the last clear or poke write.
- A reset assertion mid-clear aborts immediately. Partially cleared contents are left as-is.
- CTRL clear-start and POKE_DATA writes can only occur one per cycle (single Avalon port). Arbitration is therefore only between the internal sources.

## Test plan
- Stream 23040 `px_valid` pixels with `px_data`=cycle[1:0] and `frame_start` on the first. Expect `fb_addr` 0..23039 in order, one cycle late, and a single `frame_done` pulse after addr 23039.
- Drive `frame_start` at `wp`=500 together with `px_valid`. Expect that pixel at addr 0 and the next at addr 1.
- Write CTRL=0x0D (fill=3, clear). Expect 23040 consecutive writes of 3 to addr 0..23039, `busy` high for 23040 cycles, and PPU pixels in that window not written while `wp` still advances.
- Poke addr 0x1234 with data 2 while `px_valid` is held high. Expect `waitrequest` on a second POKE_DATA write, then the 0x1234/2 write in the first cycle after `px_valid` drops.
- With freeze=1, stream pixels and poke addr 7. Expect no PPU writes and the poke written with one cycle of latency.
- Poke addr 23040. Expect no `fb_we` and a return to IDLE. Then assert `reset_n` low mid-clear and expect every output at 0 asynchronously.

Source files
------------

// File: rtl/gb_fb_write_ctrl_if.sv
// Avalon-MM register port of the frame buffer write controller.
interface gb_fb_write_ctrl_if;
    logic       chipselect;
    logic       write;
    logic [1:0] address;
    logic [7:0] writedata;
    logic       waitrequest;

    modport master (
        output chipselect, write, address, writedata,
        input  waitrequest
    );

    modport slave (
        input  chipselect, write, address, writedata,
        output waitrequest
    );
endinterface

// File: rtl/gb_fb_write_ctrl.sv
// Frame buffer write-port arbiter: PPU stream, clear/fill sequencer, host pokes.
module gb_fb_write_ctrl #(
    parameter int FB_DEPTH   = 23040,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  px_valid,
    input  logic [1:0]            px_data,
    input  logic                  frame_start,
    gb_fb_write_ctrl_if.slave     av,
    output logic                  fb_we,
    output logic [ADDR_WIDTH-1:0] fb_addr,
    output logic [1:0]            fb_data,
    output logic                  busy,
    output logic                  frame_done
);

    typedef enum logic [1:0] {IDLE, CLEAR, POKE_WAIT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST  = ADDR_WIDTH'(FB_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH = ADDR_WIDTH'(FB_DEPTH);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wp_q, wp_d, px_addr;
    logic [ADDR_WIDTH-1:0] cc_q, cc_d;
    logic                  freeze_q;
    logic [1:0]            fill_q, fill_nx;
    logic [7:0]            poke_lo_q;
    logic [6:0]            poke_hi_q;
    logic [ADDR_WIDTH-1:0] pk_addr_q;
    logic [1:0]            pk_data_q;

    logic                  we_d, busy_d, fd_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [1:0]            data_d;

    logic wr_req, clr_req, pkd_req, wr_ok;
    logic clr_start, poke_start, ppu_we, pk_go;
    logic unused_wd;

    assign unused_wd = ^{av.writedata[7:4]};

    assign wr_req  = av.chipselect & av.write;
    assign clr_req = wr_req && av.address == 2'd0 && av.writedata[0];
    assign pkd_req = wr_req && av.address == 2'd3;

    // Only a second poke or a re-trigger of the clear can stall the host
    assign av.waitrequest = (pkd_req && state_q == POKE_WAIT)
                         || (clr_req && state_q != IDLE);

    assign wr_ok      = wr_req & ~av.waitrequest;
    assign clr_start  = clr_req && state_q == IDLE;
    assign poke_start = pkd_req && state_q == IDLE;

    assign fill_nx = (wr_ok && av.address == 2'd0) ?
                     av.writedata[3:2] : fill_q;

    assign ppu_we = px_valid & ~freeze_q;
    assign pk_go  = ~px_valid | freeze_q;

    // Pointer runs independently of who owns the write port
    always_comb begin
        px_addr = frame_start ? '0 : wp_q;
        wp_d    = wp_q;
        fd_d    = 1'b0;
        if (px_valid) begin
            wp_d = (px_addr == LAST) ? '0 : px_addr + ADDR_WIDTH'(1);
            fd_d = (px_addr == LAST);
        end else if (frame_start) begin
            wp_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        we_d    = 1'b0;
        addr_d  = fb_addr;
        data_d  = fb_data;
        busy_d  = 1'b0;
        if (ppu_we) begin
            we_d   = 1'b1;
            addr_d = px_addr;
            data_d = px_data;
        end
        unique case (state_q)
            IDLE: begin
                if (clr_start) begin
                    // First fill write goes out with the trigger edge
                    state_d = CLEAR;
                    cc_d    = ADDR_WIDTH'(1);
                    we_d    = 1'b1;
                    addr_d  = '0;
                    data_d  = fill_nx;
                    busy_d  = 1'b1;
                end else if (poke_start) begin
                    state_d = POKE_WAIT;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                we_d   = 1'b1;
                addr_d = cc_q;
                data_d = fill_nx;
                busy_d = 1'b1;
                cc_d   = cc_q + ADDR_WIDTH'(1);
                if (cc_q == LAST) state_d = IDLE;
            end
            POKE_WAIT: begin
                busy_d = 1'b1;
                if (pk_addr_q >= DEPTH) begin
                    state_d = IDLE;
                end else if (pk_go) begin
                    we_d    = 1'b1;
                    addr_d  = pk_addr_q;
                    data_d  = pk_data_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cc_q    <= '0;
            wp_q    <= '0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            wp_q    <= wp_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freeze_q  <= 1'b0;
            fill_q    <= 2'd0;
            poke_lo_q <= 8'd0;
            poke_hi_q <= 7'd0;
            pk_addr_q <= '0;
            pk_data_q <= 2'd0;
        end else begin
            fill_q <= fill_nx;
            if (wr_ok) begin
                unique case (av.address)
                    2'd0: freeze_q  <= av.writedata[1];
                    2'd1: poke_lo_q <= av.writedata;
                    2'd2: poke_hi_q <= av.writedata[6:0];
                    2'd3: pk_data_q <= av.writedata[1:0];
                    default: ;
                endcase
            end
            // Address is snapshotted so later LO/HI writes leave it alone
            if (poke_start) pk_addr_q <= ADDR_WIDTH'({poke_hi_q, poke_lo_q});
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            fb_we      <= we_d;
            fb_addr    <= addr_d;
            fb_data    <= data_d;
            busy       <= busy_d;
            frame_done <= fd_d;
        end
    end

endmodule
